// File: rtl/dec2x4_pulse_seq.sv
// dec2x4_pulse_seq: takes a 2-bit code over a valid/ready handshake and
// drives the matching one-hot line for HOLD_CYCLES cycles. After the hold it
// idles for GAP_CYCLES cycles, and only then accepts the next code.
// Optional build macro DEC_ACTIVE_LOW_EN makes o active-low (idle 4'b1111).
// in_ready, busy and done are the same in both builds.
module dec2x4_pulse_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in_valid,
  input  logic [1:0] in_code,
  output logic       in_ready,
  output logic [3:0] o,
  output logic       busy,
  output logic       done
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW     = $clog2((MAX_HG > 2) ? MAX_HG : 2);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    code;
  logic          done_q;
  logic          accept;
  logic [3:0]    o_act;

  assign in_ready = (state == S_IDLE) && en;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;

  // The one-hot line is decoded from the latched code while in HOLD. This
  // equals a registered one-hot set on accept and cleared on the final hold
  // edge, and it drops to zero at once when reset forces state to IDLE.
  assign o_act = (state == S_HOLD) ? (4'b0001 << code) : 4'b0000;

`ifdef DEC_ACTIVE_LOW_EN
  assign o = ~o_act;
`else
  assign o = o_act;
`endif

  // Sequencer: IDLE -> HOLD (count down the hold) -> optional GAP -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      code   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            code  <= in_code;
            cnt   <= HOLD_LD;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            done_q <= 1'b1;
            if (GAP_CYCLES > 0) begin
              cnt   <= GAP_LD;
              state <= S_GAP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec2x4_pulse_seq.sv
// Bench for dec2x4_pulse_seq. Accepted codes go into a queue. A monitor pops
// each code when its window opens and checks the one-hot value, the window
// length, the done pulse and the spacing between windows. A second instance
// (HOLD=1, GAP=0) checks back-to-back accepts.
module tb_dec2x4_pulse_seq;

  localparam int HOLD = 4;
  localparam int GAP  = 1;
`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [3:0] OFF = 4'hF;
`else
  localparam logic [3:0] OFF = 4'h0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, in_valid;
  logic [1:0] in_code;
  logic       in_ready, busy, done;
  logic [3:0] o;

  logic       en2, v2;
  logic [1:0] code2;
  logic       in_ready2, busy2, done2;
  logic [3:0] o2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_q[$];
  bit         abort   = 1'b0;
  bit         gap_chk = 1'b0;

  always #5 clk = ~clk;

  dec2x4_pulse_seq #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .o(o), .busy(busy), .done(done)
  );

  dec2x4_pulse_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .in_valid(v2), .in_code(code2),
    .in_ready(in_ready2), .o(o2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window monitor for the default instance, sampled on the falling edge
  logic [3:0] prev_oh = 4'h0, cur_oh = 4'h0, oh;
  int         win_len = 0, idle_cnt = 0;
  logic [1:0] e;
  always @(negedge clk) begin
    oh = o ^ OFF;
    if (oh != 4'h0 && prev_oh == 4'h0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $error("FAIL unexpected_window: observed=%0h expected=none", oh);
      end else begin
        e = exp_q.pop_front();
        chk("win_code", oh, 4'b0001 << e);
      end
      if (gap_chk) chk("win_spacing", idle_cnt, GAP + 1);
      chk("win_busy", busy, 1'b1);
      cur_oh  = oh;
      win_len = 1;
    end else if (oh != 4'h0) begin
      chk("win_stable", oh, cur_oh);
      chk("win_no_done", done, 1'b0);
      win_len++;
    end else if (prev_oh != 4'h0) begin
      if (abort) begin
        chk("abort_no_done", done, 1'b0);
        abort = 1'b0;
      end else begin
        chk("win_len", win_len, HOLD);
        chk("done_pulse", done, 1'b1);
      end
      idle_cnt = 1;
    end else begin
      chk("done_idle", done, 1'b0);
      idle_cnt++;
    end
    prev_oh = oh;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] codes[3];
    int idx;
    codes[0] = 2'd0; codes[1] = 2'd1; codes[2] = 2'd3;

    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_code = 2'd0;
    en2 = 1'b1; v2 = 1'b0; code2 = 2'd0;
    #2;
    chk("rst_o", o, OFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_o2", o2, OFF);

    // Release reset. The HOLD=1/GAP=0 instance accepts on every other edge.
    @(negedge clk);
    rst_n = 1'b1; v2 = 1'b1; code2 = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #1;
      chk("b2b_o", o2 ^ OFF, (k % 2 == 1) ? 4'b0100 : 4'b0000);
      chk("b2b_done", done2, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("b2b_ready", in_ready2, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("b2b_busy", busy2, (k % 2 == 1) ? 1'b1 : 1'b0);
    end
    v2 = 1'b0;

    // Single code 2: four-cycle window, done as o clears, five busy cycles
    @(negedge clk);
    in_valid = 1'b1; in_code = 2'd2;
    #1;
    chk("s1_ready", in_ready, 1'b1);
    exp_q.push_back(2'd2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); #1;
      if (k == 1) in_valid = 1'b0;
      chk("s1_o", o ^ OFF, (k <= 4) ? 4'b0100 : 4'b0000);
      chk("s1_busy", busy, (k <= 5) ? 1'b1 : 1'b0);
      chk("s1_done", done, (k == 5) ? 1'b1 : 1'b0);
      chk("s1_ready_k", in_ready, (k >= 6) ? 1'b1 : 1'b0);
    end

    // Continuous valid. Random codes are presented while not ready, and each
    // real code is presented only on a ready cycle.
    idx = 0;
    in_valid = 1'b1;
    for (int g = 0; g < 80 && idx < 3; g++) begin
      in_code = 2'($urandom_range(3));
      #1;
      if (in_ready) begin
        in_code = codes[idx];
        exp_q.push_back(codes[idx]);
        idx++;
      end
      @(negedge clk); #1;
      if (idx >= 1) gap_chk = 1'b1;
    end
    in_valid = 1'b0;
    if (idx < 3) begin
      n_cmp++; n_bad++;
      $error("FAIL s2_accept_timeout: observed=%0d expected=3", idx);
    end
    repeat (8) @(negedge clk);
    #1;
    gap_chk = 1'b0;

    // en low: nothing is accepted even though in_valid is high
    en = 1'b0; in_valid = 1'b1; in_code = 2'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      chk("en0_ready", in_ready, 1'b0);
      chk("en0_o", o ^ OFF, 4'b0000);
      chk("en0_busy", busy, 1'b0);
    end
    en = 1'b1;
    #1;
    chk("en1_ready", in_ready, 1'b1);
    exp_q.push_back(2'd1);
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk("en1_o", o ^ OFF, 4'b0010);
    repeat (8) @(negedge clk);
    #1;

    // Code 3, then drop en and toggle in_code during the hold
    en = 1'b1; in_valid = 1'b1; in_code = 2'd3;
    #1;
    chk("s4_ready", in_ready, 1'b1);
    exp_q.push_back(2'd3);
    @(negedge clk); #1;
    in_valid = 1'b0; en = 1'b0; in_code = 2'd0;
    chk("s4_o1", o ^ OFF, 4'b1000);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk); #1;
      in_code = ~in_code;
      chk("s4_o", o ^ OFF, (k <= 4) ? 4'b1000 : 4'b0000);
      chk("s4_done", done, (k == 5) ? 1'b1 : 1'b0);
      if (k == 6) begin
        chk("s4_ready_en0", in_ready, 1'b0);
        chk("s4_busy_end", busy, 1'b0);
      end
    end
    en = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Reset asserted between edges during a hold
    in_valid = 1'b1; in_code = 2'd1;
    #1;
    chk("s5_ready", in_ready, 1'b1);
    exp_q.push_back(2'd1);
    @(negedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); #1;
    chk("s5_o_hold", o ^ OFF, 4'b0010);
    @(posedge clk); #2;
    abort = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_o", o, OFF);
    chk("s5_rst_busy", busy, 1'b0);
    chk("s5_rst_done", done, 1'b0);
    chk("s5_rst_ready", in_ready, 1'b1);
    @(negedge clk); #1;
    chk("s5_rst_done2", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("s5_rel_ready", in_ready, 1'b1);
    chk("s5_rel_busy", busy, 1'b0);
    chk("s5_rel_o", o, OFF);
    repeat (4) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
